riscv_btb_assoc: RTL

- Parametrised set-associative branch target buffer with N-bit saturating direction counters, for the RV64 fetch stage.
- Lookup is combinational on the IF PC. The EX stage trains it through a registered update port.
- Adds three things over a direct-mapped BTB: multiple ways with round-robin victim selection, configurable counter width, and a sequential flush/init sweep FSM with a busy indication.

---
 rtl/riscv_btb_assoc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and a flush sweep.
// Define BTB_PERF_EN to add the hit/allocation/mispredict performance counters.
module riscv_btb_assoc #(
  parameter int PC_LEN   = 64,
  parameter int SETS     = 256,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2,
  parameter int IDX_LSB  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_valid,
  input  logic [PC_LEN-1:0] i_if_pc,
  output logic              o_pred_valid,
  output logic              o_pred_taken,
  output logic [PC_LEN-1:0] o_pred_target,
  input  logic              i_upd_valid,
  input  logic              i_upd_jump,
  input  logic [PC_LEN-1:0] i_upd_pc,
  input  logic [PC_LEN-1:0] i_upd_target,
  input  logic              i_upd_taken,
  input  logic              i_flush,
  output logic              o_busy
`ifdef BTB_PERF_EN
  ,
  output logic [31:0]       o_perf_hits,
  output logic [31:0]       o_perf_allocs,
  output logic [31:0]       o_perf_mispred
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_LEN - IDX_LSB - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WN  = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               busy;

  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [PC_LEN-1:0]   tgt_q   [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0]    rr_q    [SETS];

  logic [IDX_W-1:0]    if_idx, u_idx;
  logic [TAG_W-1:0]    if_tag, u_tag;
  logic                lk_hit, lk_msb;
  logic [PC_LEN-1:0]   lk_tgt;
  logic                u_act, u_hit, u_free, u_evict;
  logic [WAY_W-1:0]    u_hit_way, u_free_way, u_way, rr_next;
  logic [CTR_BITS-1:0] u_old_ctr, u_new_ctr;

  assign busy   = (state_q == ST_SWEEP);
  assign o_busy = busy;
  assign if_idx = i_if_pc[IDX_LSB +: IDX_W];
  assign if_tag = i_if_pc[PC_LEN-1 -: TAG_W];
  assign u_idx  = i_upd_pc[IDX_LSB +: IDX_W];
  assign u_tag  = i_upd_pc[PC_LEN-1 -: TAG_W];
  assign u_act  = (i_upd_valid | i_upd_jump) & ~busy & ~i_rst;

  generate
    if (IDX_LSB > 0) begin : g_unused
      logic unused_lsbs;
      assign unused_lsbs = ^{i_if_pc[IDX_LSB-1:0], i_upd_pc[IDX_LSB-1:0]};
    end
  endgenerate

  always_comb begin
    lk_hit = 1'b0;
    lk_msb = 1'b0;
    lk_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[if_idx][w] && tag_q[if_idx][w] == if_tag) begin
        lk_hit = 1'b1;
        lk_msb = ctr_q[if_idx][w][CTR_BITS-1];
        lk_tgt = tgt_q[if_idx][w];
      end
    end
  end

  assign o_pred_valid  = i_if_valid & ~busy & lk_hit;
  assign o_pred_taken  = o_pred_valid & lk_msb;
  assign o_pred_target = lk_tgt;

  // Hit detection always wins over allocation so a set never holds the same tag twice.
  always_comb begin
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (!valid_q[u_idx][w] && !u_free) begin
        u_free     = 1'b1;
        u_free_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    u_way     = u_hit ? u_hit_way : (u_free ? u_free_way : rr_q[u_idx]);
    u_evict   = u_act & ~u_hit & ~u_free;
    u_old_ctr = ctr_q[u_idx][u_hit_way];
    rr_next   = '0;
    if (WAYS > 1 && rr_q[u_idx] != WAY_W'(WAYS-1)) rr_next = rr_q[u_idx] + 1'b1;
    if (u_hit) begin
      if (i_upd_jump)       u_new_ctr = CTR_MAX;
      else if (i_upd_taken) u_new_ctr = (u_old_ctr == CTR_MAX) ? u_old_ctr : u_old_ctr + 1'b1;
      else                  u_new_ctr = (u_old_ctr == '0) ? u_old_ctr : u_old_ctr - 1'b1;
    end else begin
      if (i_upd_jump)       u_new_ctr = CTR_MAX;
      else if (i_upd_taken) u_new_ctr = CTR_WT;
      else                  u_new_ctr = CTR_WN;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_SWEEP: begin
        if (i_flush) begin
          ptr_d = '0;
        end else if (ptr_q == IDX_W'(SETS-1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (i_flush) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Table storage has no reset; the sweep clears valid bits one set per cycle.
  always_ff @(posedge i_clk) begin
    if (busy) begin
      for (int w = 0; w < WAYS; w++) valid_q[ptr_q][w] <= 1'b0;
      rr_q[ptr_q] <= '0;
    end else if (u_act) begin
      valid_q[u_idx][u_way] <= 1'b1;
      tag_q[u_idx][u_way]   <= u_tag;
      tgt_q[u_idx][u_way]   <= i_upd_target;
      ctr_q[u_idx][u_way]   <= u_new_ctr;
      if (u_evict) rr_q[u_idx] <= rr_next;
    end
  end

`ifdef BTB_PERF_EN
  logic [31:0] hits_q, hits_d, allocs_q, allocs_d, mispred_q, mispred_d;

  always_comb begin
    hits_d    = hits_q + 32'(o_pred_valid);
    allocs_d  = allocs_q + 32'(u_act & ~u_hit);
    mispred_d = mispred_q + 32'(u_act & ~i_upd_jump & u_hit & (u_old_ctr[CTR_BITS-1] != i_upd_taken));
    if (i_flush) begin
      hits_d    = '0;
      allocs_d  = '0;
      mispred_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hits_q    <= '0;
      allocs_q  <= '0;
      mispred_q <= '0;
    end else begin
      hits_q    <= hits_d;
      allocs_q  <= allocs_d;
      mispred_q <= mispred_d;
    end
  end

  assign o_perf_hits    = hits_q;
  assign o_perf_allocs  = allocs_q;
  assign o_perf_mispred = mispred_q;
`endif

endmodule
